// File: rtl/franken_io_pkg.sv
// Shared definitions for the franken_io peripheral: register select bits,
// status bit positions and the UART transmitter states.
package franken_io_pkg;

  localparam int unsigned IO_LEDS      = 0;
  localparam int unsigned IO_UART_DAT  = 1;
  localparam int unsigned IO_UART_CNTL = 2;

  localparam int unsigned ST_ACTIVE = 8;
  localparam int unsigned ST_FULL   = 9;
  localparam int unsigned ST_OVF    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/franken_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags. A push is accepted
// when full if a pop happens in the same cycle.
module franken_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign rdata_c   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: the flags guard every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/franken_io.sv
// Memory-mapped IO page: LED register, 8N1 UART transmitter and status register.
// Define FRANKEN_IO_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise one holding register.
module franken_io
  import franken_io_pkg::*;
#(
  parameter int unsigned LED_W       = 6,
  parameter int unsigned CLK_HZ      = 27000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned IO_PAGE_BIT = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [31:0]      wdata,
  output logic             is_io,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  output logic             TXD
);
  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("franken_io: CLK_HZ/BAUD must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  tx_state_e        state;
  logic [CW-1:0]    baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [LED_W-1:0] led_reg;
  logic             ovf;
  logic [2:0]       sel;
  logic             wr_leds;
  logic             push;
  logic             rd_io;
  logic             rd_cntl;
  logic             accept;
  logic             pop;
  logic             baud_last;
  logic             active;
  logic             buf_full;
  logic             buf_empty;
  logic [7:0]       buf_data;
  logic [31:0]      status;
  logic [31:0]      rd_val;
  logic             unused_bits;

  assign is_io       = addr[IO_PAGE_BIT];
  assign sel         = addr[4:2];
  assign wr_leds     = wr_en & is_io & sel[IO_LEDS];
  assign push        = wr_en & is_io & sel[IO_UART_DAT];
  assign rd_io       = rd_en & is_io;
  assign rd_cntl     = rd_io & sel[IO_UART_CNTL];
  assign baud_last   = (baud_cnt == CW'(DIV - 1));
  assign pop         = ~buf_empty & ((state == IDLE) | ((state == STOP) & baud_last));
  assign accept      = push & (~buf_full | pop);
  assign active      = (state != IDLE) | ~buf_empty;
  assign led         = ~led_reg;
  assign unused_bits = ^{addr, wdata};

`ifdef FRANKEN_IO_TX_FIFO_EN
  franken_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (pop),
    .wdata   (wdata[7:0]),
    .rdata_c (buf_data),
    .full    (buf_full),
    .empty   (buf_empty)
  );
`else
  logic       hold_vld;
  logic [7:0] hold_data;

  // Single holding register: refilled in the same cycle it is popped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_vld  <= 1'b1;
      hold_data <= wdata[7:0];
    end else if (pop) begin
      hold_vld  <= 1'b0;
    end
  end

  assign buf_full  = hold_vld;
  assign buf_empty = ~hold_vld;
  assign buf_data  = hold_data;
`endif

  always_comb begin
    status            = '0;
    status[ST_ACTIVE] = active;
    status[ST_FULL]   = buf_full;
    status[ST_OVF]    = ovf;
    rd_val            = '0;
    if (rd_io & sel[IO_LEDS]) rd_val = rd_val | 32'(led_reg);
    if (rd_cntl)              rd_val = rd_val | status;
  end

  // Bus side: LED register, sticky overflow (set beats clear), read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_reg <= '0;
      ovf     <= 1'b0;
      rdata   <= '0;
    end else begin
      if (wr_leds) led_reg <= wdata[LED_W-1:0];
      if (push & ~accept) ovf <= 1'b1;
      else if (rd_cntl)   ovf <= 1'b0;
      rdata <= rd_val;
    end
  end

  // TX framing: start bit, 8 data bits LSB first, stop bit, DIV cycles each.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      TXD      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            shreg    <= buf_data;
            baud_cnt <= '0;
            TXD      <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            TXD      <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TXD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TXD     <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              state <= START;
              shreg <= buf_data;
              TXD   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_franken_io.sv
// Self-checking bench for franken_io: vector table, hand-written UART sequences,
// and random traffic against a frame-level reference model.
module tb_franken_io;
  localparam int unsigned LED_W      = 6;
  localparam int unsigned CLK_HZ     = 1000000;
  localparam int unsigned BAUD       = 100000;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          DIV        = 10;
  localparam int          FRAME      = 10 * DIV;
`ifdef FRANKEN_IO_TX_FIFO_EN
  localparam int CAP = FIFO_DEPTH;
`else
  localparam int CAP = 1;
`endif

  // Word-address one-hot select: LEDS = addr[2], UART_DAT = addr[3], UART_CNTL = addr[4].
  localparam logic [31:0] A_LEDS = 32'h0040_0004;
  localparam logic [31:0] A_DAT  = 32'h0040_0008;
  localparam logic [31:0] A_CNTL = 32'h0040_0010;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [31:0]      addr  = '0;
  logic [31:0]      wdata = '0;
  logic             is_io;
  logic [31:0]      rdata;
  logic [LED_W-1:0] led;
  logic             txd;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  franken_io #(
    .LED_W       (LED_W),
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .IO_PAGE_BIT (22)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .is_io (is_io),
    .rdata (rdata),
    .led   (led),
    .TXD   (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic rd,
                       input logic [31:0] d);
    reset = r;
    addr  = a;
    wr_en = w;
    rd_en = rd;
    wdata = d;
  endtask

  task automatic idle();
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Line level at bit slot b of a frame carrying byte d (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Reference model: byte queue of capacity CAP, frames back to back, FRAME cycles each.
  logic [7:0]       q[$];
  int               busy    = 0;
  logic [7:0]       cur     = '0;
  logic             m_ovf   = 1'b0;
  logic [LED_W-1:0] m_led   = '0;
  logic [31:0]      m_rdata = '0;

  function automatic logic exp_txd();
    if (busy == 0) return 1'b1;
    return frame_bit(cur, (FRAME - busy) / DIV);
  endfunction

  always @(posedge clk) begin
    logic        io, mpush, mpop;
    logic [2:0]  s;
    logic [31:0] st, nrd;
    if (!reset) begin
      q.delete();
      busy    = 0;
      m_ovf   = 1'b0;
      m_led   = '0;
      m_rdata = '0;
    end else begin
      io = addr[22];
      s  = addr[4:2];
      st = '0;
      st[8]  = (busy > 0) || (q.size() > 0);
      st[9]  = (q.size() >= CAP);
      st[10] = m_ovf;
      nrd = '0;
      if (rd_en && io && s[0]) nrd = nrd | 32'(m_led);
      if (rd_en && io && s[2]) nrd = nrd | st;
      mpop = (q.size() > 0) && (busy <= 1);
      if (mpop) begin
        cur  = q.pop_front();
        busy = FRAME;
      end else if (busy > 0) begin
        busy--;
      end
      mpush = wr_en && io && s[1];
      if (rd_en && io && s[2]) m_ovf = 1'b0;
      if (mpush) begin
        if (q.size() < CAP) q.push_back(wdata[7:0]);
        else m_ovf = 1'b1;
      end
      if (wr_en && io && s[0]) m_led = wdata[LED_W-1:0];
      m_rdata = nrd;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rdata", rdata, m_rdata);
      check("model_led", 32'(led), 32'(LED_W'(~m_led)));
      check("model_txd", 32'(txd), 32'(exp_txd()));
      check("model_is_io", 32'(is_io), 32'(addr[22]));
    end
  end

  typedef struct {
    logic        rst_n;
    logic [31:0] addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_led;
  } vec_t;

  vec_t vecs[$];
  logic pat_a5[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    int nf;
    logic e;
    vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,   6'h3F});
    vecs.push_back('{1'b0, A_LEDS,        1'b1, 1'b0, 32'h15,        32'h0,   6'h3F});
    vecs.push_back('{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,   6'h3F});
    vecs.push_back('{1'b1, A_CNTL,        1'b0, 1'b1, 32'h0,         32'h0,   6'h3F});
    vecs.push_back('{1'b1, A_LEDS,        1'b1, 1'b0, 32'h15,        32'h0,   6'h2A});
    vecs.push_back('{1'b1, A_LEDS,        1'b0, 1'b1, 32'h0,         32'h15,  6'h2A});
    vecs.push_back('{1'b1, 32'h0000_0004, 1'b0, 1'b1, 32'h0,         32'h0,   6'h2A});
    vecs.push_back('{1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h3F,        32'h0,   6'h2A});
    vecs.push_back('{1'b1, A_DAT,         1'b0, 1'b1, 32'h0,         32'h0,   6'h2A});
    vecs.push_back('{1'b1, 32'h0040_0000, 1'b0, 1'b1, 32'h0,         32'h0,   6'h2A});
    vecs.push_back('{1'b1, A_LEDS,        1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0,   6'h3F});
    vecs.push_back('{1'b1, A_LEDS,        1'b1, 1'b0, 32'h3F,        32'h0,   6'h00});
    vecs.push_back('{1'b1, 32'h0040_0007, 1'b0, 1'b1, 32'h0,         32'h3F,  6'h00});
    vecs.push_back('{1'b1, 32'h0040_000C, 1'b0, 1'b1, 32'h0,         32'h3F,  6'h00});
    vecs.push_back('{1'b1, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,   6'h00});

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
      tick();
      chk_en = 1'b1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
      if (i == 0) check("reset_txd", 32'(txd), 32'h1);
    end

    // Single 0xA5 frame with status polled every cycle.
    drive(1'b1, A_DAT, 1'b1, 1'b0, 32'hA5);
    tick();
    check("a5_txd_before", 32'(txd), 32'h1);
    drive(1'b1, A_CNTL, 1'b0, 1'b1, 32'h0);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      check($sformatf("a5_txd_c%0d", c), 32'(txd), 32'(pat_a5[c / DIV]));
      if (c > 0) check($sformatf("a5_active_c%0d", c), rdata, 32'h100);
    end
    tick();
    check("a5_txd_after", 32'(txd), 32'h1);
    check("a5_active_stop", rdata, 32'h100);
    tick();
    check("a5_inactive", rdata, 32'h0);
    idle();
    tick();

    // Six back-to-back stores: overflow, status reads, gapless frames.
    nf = (CAP + 1 < 5) ? CAP + 1 : 5;
    for (int t = 0; t <= nf * FRAME + 2; t++) begin
      if (t < 6) drive(1'b1, A_DAT, 1'b1, 1'b0, 32'(t + 1));
      else if (t == 6 || t == 7 || t == nf * FRAME + 2) drive(1'b1, A_CNTL, 1'b0, 1'b1, 32'h0);
      else idle();
      tick();
      if (t == 6) check("ovf_cntl_first", rdata, 32'h700);
      if (t == 7) check("ovf_cntl_second", rdata, 32'h300);
      if (t == nf * FRAME + 2) check("ovf_done_idle", rdata, 32'h0);
      if (t >= 1 && t <= nf * FRAME)
        e = frame_bit(8'((t - 1) / FRAME + 1), ((t - 1) % FRAME) / DIV);
      else
        e = 1'b1;
      check($sformatf("ovf_txd_t%0d", t), 32'(txd), 32'(e));
    end
    idle();
    tick();

    // Reset during data bit 3 of 0x35 with a second byte queued.
    drive(1'b1, A_DAT, 1'b1, 1'b0, 32'h35);
    tick();
    drive(1'b1, A_DAT, 1'b1, 1'b0, 32'hC3);
    tick();
    idle();
    for (int t = 2; t < 45; t++) tick();
    check("mid_bit3_low", 32'(txd), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    check("mid_reset_txd", 32'(txd), 32'h1);
    check("mid_reset_led", 32'(led), 32'h3F);
    check("mid_reset_rdata", rdata, 32'h0);
    idle();
    for (int t = 0; t < 2 * FRAME; t++) begin
      tick();
      check($sformatf("mid_quiet_t%0d", t), 32'(txd), 32'h1);
    end
    drive(1'b1, A_CNTL, 1'b0, 1'b1, 32'h0);
    tick();
    check("mid_cntl_clear", rdata, 32'h0);

    // LEDS + UART_CNTL selected together while a frame is on the line.
    drive(1'b1, A_LEDS, 1'b1, 1'b0, 32'h3F);
    tick();
    drive(1'b1, A_DAT, 1'b1, 1'b0, 32'h55);
    tick();
    idle();
    for (int t = 0; t < 5; t++) tick();
    drive(1'b1, 32'h0040_0014, 1'b0, 1'b1, 32'h0);
    tick();
    check("multi_select_rdata", rdata, 32'h13F);
    idle();
    for (int t = 0; t < FRAME + 5; t++) tick();

    // Random traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] a;
      a     = $urandom;
      a[22] = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 299) != 0), a, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), $urandom);
      tick();
    end
    idle();
    for (int t = 0; t < 2 * FRAME * (CAP + 1); t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
